// File: rtl/clock_divider_if.sv
// Divided-clock bundle produced by clock_divider.
// The divider owns the master side; consumers attach to the slave side.
interface clock_divider_if;
  logic clk2;
  logic clk4;
  logic clk8;

  modport master (output clk2, clk4, clk8);
  modport slave  (input  clk2, clk4, clk8);
endinterface

// File: rtl/clock_divider.sv
// Divide-by-2/4/8 clock generator.
// A single free-running 3-bit counter provides all three outputs, so they stay
// phase-locked to each other and to clk. Every output is a bare flop bit with
// no logic after it, which keeps them glitch-free.
module clock_divider (
  input  logic            clk,
  input  logic            rst,
  clock_divider_if.master div
);

  logic [2:0] cnt;

  // Free-running modulo-8 count; the 111 -> 000 wrap is an ordinary increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 3'b000;
    else     cnt <= cnt + 3'd1;
  end

  assign div.clk2 = cnt[0];
  assign div.clk4 = cnt[1];
  assign div.clk8 = cnt[2];

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: reset hold, release sequence, period/duty,
// alignment, asynchronous mid-run reset and wrap continuity.
`timescale 1ns/1ps
module tb_clock_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  clock_divider_if dif ();

  clock_divider dut (
    .clk (clk),
    .rst (rst),
    .div (dif)
  );

  always #10 clk = ~clk;

  // Period and high-time monitors, active only during the free-run window.
  logic mon = 1'b0;
  time  r2 = 0, r4 = 0, r8 = 0;
  bit   v2 = 0, v4 = 0, v8 = 0;
  time  p2 = 0, p4 = 0, p8 = 0;
  time  h2 = 0, h4 = 0, h8 = 0;
  int   dev = 0;

  always @(posedge dif.clk2) if (mon) begin
    if (v2) begin p2 = $time - r2; if (p2 != 40) dev++; end
    r2 = $time; v2 = 1;
  end
  always @(negedge dif.clk2) if (mon && v2) begin
    h2 = $time - r2; if (h2 != 20) dev++;
  end
  always @(posedge dif.clk4) if (mon) begin
    if (v4) begin p4 = $time - r4; if (p4 != 80) dev++; end
    r4 = $time; v4 = 1;
  end
  always @(negedge dif.clk4) if (mon && v4) begin
    h4 = $time - r4; if (h4 != 40) dev++;
  end
  always @(posedge dif.clk8) if (mon) begin
    if (v8) begin p8 = $time - r8; if (p8 != 160) dev++; end
    r8 = $time; v8 = 1;
  end
  always @(negedge dif.clk8) if (mon && v8) begin
    h8 = $time - r8; if (h8 != 80) dev++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [2:0] outs();
    return {dif.clk8, dif.clk4, dif.clk2};
  endfunction

  initial begin
    logic [2:0] seq [8];
    logic [2:0] prev, cur, exp;
    bit found;

    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b011; seq[3] = 3'b100;
    seq[4] = 3'b101; seq[5] = 3'b110; seq[6] = 3'b111; seq[7] = 3'b000;

    // Reset hold for 100 ns, sampled on both clk phases.
    repeat (5) begin
      @(posedge clk); #1;
      chk("reset_hold_pos", outs(), 3'b000);
      @(negedge clk);
      chk("reset_hold_neg", outs(), 3'b000);
    end

    // Release between edges (t=100 ns), then the 8-edge sequence.
    rst = 1'b0;
    mon = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("release_seq_edge%0d", i + 1), outs(), seq[i]);
    end

    // Free run to 64 edges: value, alignment of falls and clk8 rises.
    prev = outs();
    for (int k = 9; k <= 64; k++) begin
      @(posedge clk); #1;
      cur = outs();
      chk($sformatf("freerun_edge%0d", k), cur, seq[(k - 1) % 8]);
      if (k % 8 == 0)
        chk($sformatf("all_fall_edge%0d", k), {prev, cur}, {3'b111, 3'b000});
      if (!prev[2] && cur[2])
        chk($sformatf("clk8_rise_align_edge%0d", k), {prev[1] & ~cur[1], prev[0] & ~cur[0]}, 2'b11);
      prev = cur;
    end
    mon = 1'b0;
    chk("period_clk2", 32'(p2), 40);
    chk("period_clk4", 32'(p4), 80);
    chk("period_clk8", 32'(p8), 160);
    chk("high_clk2", 32'(h2), 20);
    chk("high_clk4", 32'(h4), 40);
    chk("high_clk8", 32'(h8), 80);
    chk("period_duty_deviations", dev, 0);

    // Reach cnt=110 (bounded), then assert reset away from any edge.
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(posedge clk); #1;
      if (outs() == 3'b110) found = 1;
    end
    chk("reach_110", {31'd0, found}, 1);
    #5;
    rst = 1'b1;
    #1;
    chk("async_reset_immediate", outs(), 3'b000);
    @(posedge clk); #1;
    chk("async_reset_held_edge", outs(), 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("restart_edge1", outs(), 3'b001);
    @(posedge clk); #1;
    chk("restart_edge2", outs(), 3'b010);

    // Wrap continuity across several wraps: strict +1 each edge.
    exp = 3'b010;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      exp = exp + 3'd1;
      chk($sformatf("wrap_run_%0d", k), outs(), exp);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Generates divide-by-2, divide-by-4 and divide-by-8 clocks from one input clock.
- Uses a single free-running binary counter, so all three outputs stay phase-locked to each other and to clk.
- Sits at the clock-generation front of a design and feeds slower logic domains or observation pins.
- All outputs come directly from flops, so they are glitch-free.

Parameters:
- None. The division ratios 2, 4 and 8 are fixed.

Ports:
- clk  input  1  source clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- clk2  output  1  clk divided by 2, 50% duty
- clk4  output  1  clk divided by 4, 50% duty
- clk8  output  1  clk divided by 8, 50% duty

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- State: a 3-bit counter cnt[2:0].
- Output mapping, each output driven directly from a flop bit with no combinational logic after it:
  - clk2 = cnt[0]
  - clk4 = cnt[1]
  - clk8 = cnt[2]
- Reset:
  - While rst=1, cnt=3'b000 and clk2=clk4=clk8=0 immediately, independent of clk.
  - Reset asserted mid-count forces all outputs low at once, with no waiting for a clk edge.
- Counting: on each rising clk edge with rst=0, cnt <= cnt+1, modulo 8.
- Wrap: 3'b111 -> 3'b000 is a normal increment; no idle cycle, no stall.
- Output toggle rates relative to rising clk edges:
  - clk2 toggles on every edge (period 2 clk periods).
  - clk4 toggles every 2nd edge (period 4).
  - clk8 toggles every 4th edge (period 8).
- Sequence after reset release, numbering rising edges from 1:
  - Edge 1: clk2=1, clk4=0, clk8=0.
  - Edge 2: clk2=0, clk4=1.
  - Edge 4: clk8=1.
  - Edge 8: all three outputs fall together.
  - Thereafter the pattern repeats every 8 edges.
- Phase alignment:
  - Every output transition coincides with a rising clk edge, after clk-to-q delay.
  - Falling edges of clk2, clk4 and clk8 coincide every 8 clk cycles.
  - A rising edge of clk8 coincides with a falling edge of clk4 and of clk2.
- Duty cycle: exactly 50% on all outputs, i.e. high for 1, 2 and 4 clk periods respectively.
- Reset release: if rst deasserts near a rising clk edge, the first count may occur on that edge or the next. Either is acceptable. The counter never takes an illegal value, since all 8 values are legal.
- Output usage: outputs are data-path flop outputs. Downstream use as real clocks needs clock buffering, which is outside this block.

Test Plan:
- Reset hold: clk period 20 ns, rst=1 for 100 ns -> clk2=clk4=clk8=0 throughout, including across clk edges.
- Release and count: rst 1->0 between clk edges -> over the next 8 rising edges, {clk8,clk4,clk2} reads 001, 010, 011, 100, 101, 110, 111, 000.
- Period and duty: free-run for 64 clk cycles after release -> measured periods 40/80/160 ns, high times 20/40/80 ns, no deviation.
- Alignment: after release, check every 8th edge -> all three outputs fall on the same rising clk edge. Also check that clk8 rises only together with clk4 and clk2 falling.
- Async reset mid-run: assert rst at cnt=3'b110, away from any clk edge -> outputs go to 000 within the same timestep. On release, the sequence restarts at 001.
- Wrap continuity: run past several wraps -> no output holds for an extra cycle at the 111->000 transition.
